// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner
//  Description : Per-channel two-flop synchronizer, debouncer and edge
//                detector for raw board pins, with press/release/auto-repeat
//                one-cycle pulses in the clk domain.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat
);

    localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DB_W-1:0] c_DB_ONE  = c_DB_W'(1);

    localparam int c_HOLD_SPAN = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int c_H_W       = $clog2(c_HOLD_SPAN + 1);
    localparam logic [c_H_W-1:0] c_HOLD_LAST = c_H_W'(HOLD_CYCLES - 1);
    localparam logic [c_H_W-1:0] c_REP_LAST  = c_H_W'(REPEAT_CYCLES - 1);
    localparam logic [c_H_W-1:0] c_H_ONE     = c_H_W'(1);

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
        logic              r_sync1;
        logic              r_sync2;
        logic              r_level;
        logic              r_press;
        logic              r_release;
        logic [c_DB_W-1:0] r_db_cnt;
        logic              w_toggle;

        // The level flips on the edge at which the disagreement run reaches
        // DEBOUNCE_CYCLES; any agreeing cycle restarts the run.
        assign w_toggle = (r_sync2 != r_level) && (r_db_cnt == c_DB_LAST);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync1   <= 1'b0;
                r_sync2   <= 1'b0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_db_cnt  <= '0;
            end else begin
                r_sync1   <= btn_in[gi];
                r_sync2   <= r_sync1;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                if (r_sync2 == r_level) begin
                    r_db_cnt <= '0;
                end else if (w_toggle) begin
                    r_db_cnt  <= '0;
                    r_level   <= ~r_level;
                    r_press   <= ~r_level;
                    r_release <= r_level;
                end else begin
                    r_db_cnt <= r_db_cnt + c_DB_ONE;
                end
            end
        end

        assign btn_level[gi]   = r_level;
        assign btn_press[gi]   = r_press;
        assign btn_release[gi] = r_release;

        if (REPEAT_CYCLES > 0) begin : g_repeat
            logic [c_H_W-1:0] r_hold_cnt;
            logic             r_rep_phase;
            logic             r_repeat;
            logic [c_H_W-1:0] w_hold_target;

            assign w_hold_target = r_rep_phase ? c_REP_LAST : c_HOLD_LAST;

            // Hold timing is gated off on the falling edge itself so no repeat
            // can appear in the first cycle the level reads 0.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_hold_cnt  <= '0;
                    r_rep_phase <= 1'b0;
                    r_repeat    <= 1'b0;
                end else if (!r_level || w_toggle) begin
                    r_hold_cnt  <= '0;
                    r_rep_phase <= 1'b0;
                    r_repeat    <= 1'b0;
                end else if (r_hold_cnt == w_hold_target) begin
                    r_hold_cnt  <= '0;
                    r_rep_phase <= 1'b1;
                    r_repeat    <= 1'b1;
                end else begin
                    r_hold_cnt  <= r_hold_cnt + c_H_ONE;
                    r_repeat    <= 1'b0;
                end
            end

            assign btn_repeat[gi] = r_repeat;
        end else begin : g_no_repeat
            assign btn_repeat[gi] = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_conditioner
//  Description : Self-checking bench for button_conditioner: directed
//                scenarios plus randomized pins against a timestamp model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int NB = 2;
    localparam int D  = 4;
    localparam int H  = 10;
    localparam int R  = 5;

    logic          clk;
    logic          rst;
    logic [NB-1:0] btn_in;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_repeat;

    int n_checks = 0;
    int n_errors = 0;

    button_conditioner #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Model: pin reaches the debouncer two edges late; the level flips once
    // D consecutive edges have disagreed since the last agreement/flip.
    // Repeats fall at press_edge + H + k*R while the level stays high.
    int t = 0;
    int m_d1 [NB];
    int m_d2 [NB];
    int m_lvl[NB];
    int m_last[NB];
    int m_pe [NB];
    int m_press[NB];
    int m_rel[NB];
    int m_rep[NB];

    always @(posedge clk) begin
        t++;
        for (int c = 0; c < NB; c++) begin
            if (rst) begin
                m_d1[c] = 0; m_d2[c] = 0; m_lvl[c] = 0; m_last[c] = t;
                m_pe[c] = t; m_press[c] = 0; m_rel[c] = 0; m_rep[c] = 0;
            end else begin
                int s;
                s        = m_d2[c];
                m_d2[c]  = m_d1[c];
                m_d1[c]  = int'(btn_in[c]);
                m_press[c] = 0;
                m_rel[c]   = 0;
                if (s == m_lvl[c]) begin
                    m_last[c] = t;
                end else if (t - m_last[c] == D) begin
                    m_lvl[c]  = s;
                    m_last[c] = t;
                    if (s == 1) begin
                        m_press[c] = 1;
                        m_pe[c]    = t;
                    end else begin
                        m_rel[c] = 1;
                    end
                end
                m_rep[c] = (R > 0 && m_lvl[c] == 1 && (t - m_pe[c]) >= H &&
                            ((t - m_pe[c] - H) % R) == 0) ? 1 : 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int c = 0; c < NB; c++) begin
            chk($sformatf("model_ch%0d{lvl,prs,rel,rep}", c),
                int'({btn_level[c], btn_press[c], btn_release[c], btn_repeat[c]}),
                (m_lvl[c] << 3) | (m_press[c] << 2) | (m_rel[c] << 1) | m_rep[c]);
            chk($sformatf("press_rep_excl_ch%0d", c), int'(btn_press[c] & btn_repeat[c]), 0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Cycles until a press pulse on channel ch (-1 on timeout); also counts releases seen.
    task automatic wait_press(input int ch, output int n, output int rels);
        n    = -1;
        rels = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (btn_release[ch]) rels++;
            if (btn_press[ch]) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic settle(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    initial begin
        int n, rels, cnt, cnt2;
        int offs[$];
        logic [NB-1:0] pat [6];

        rst    = 1'b1;
        btn_in = '0;
        settle(3);
        chk("reset_outputs", int'({btn_level, btn_press, btn_release, btn_repeat}), 0);
        rst = 1'b0;
        settle(3);

        // Clean press on ch0, then hold into auto-repeat
        btn_in[0] = 1'b1;
        cnt = 0;
        n   = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (btn_level[1] | btn_press[1] | btn_release[1] | btn_repeat[1]) cnt++;
            if (btn_press[0]) begin
                n = i;
                break;
            end
        end
        chk("clean_press_latency", n, 6);
        chk("clean_ch1_quiet", cnt, 0);
        offs.delete();
        cnt = 0;
        for (int i = 1; i <= 39; i++) begin
            tick();
            if (btn_press[0]) cnt++;
            if (btn_repeat[0]) offs.push_back(i);
        end
        chk("press_single_cycle", cnt, 0);
        chk("repeat_count", offs.size(), 6);
        for (int k = 0; k < 6; k++)
            chk($sformatf("repeat_offset_%0d", k), (k < offs.size()) ? offs[k] : -1, 10 + 5 * k);
        btn_in[0] = 1'b0;
        cnt  = 0;
        cnt2 = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (btn_release[0]) cnt++;
            if (!btn_level[0] && btn_repeat[0]) cnt2++;
        end
        chk("release_once", cnt, 1);
        chk("no_repeat_after_fall", cnt2, 0);

        // Bounce on ch0
        pat[0] = 2'b01; pat[1] = 2'b00; pat[2] = 2'b01;
        pat[3] = 2'b01; pat[4] = 2'b00; pat[5] = 2'b01;
        n   = -1;
        cnt = 0;
        for (int i = 1; i <= 25; i++) begin
            btn_in[0] = (i <= 6) ? pat[i-1][0] : 1'b1;
            tick();
            if (btn_press[0]) begin
                cnt++;
                if (n < 0) n = i;
            end
        end
        chk("bounce_press_latency", n, 11);
        chk("bounce_single_press", cnt, 1);
        btn_in[0] = 1'b0;
        settle(10);

        // Glitch on ch1
        btn_in[1] = 1'b1;
        settle(3);
        btn_in[1] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (btn_level[1] | btn_press[1] | btn_release[1]) cnt++;
        end
        chk("glitch_rejected", cnt, 0);

        // Reset while held in repeat phase
        btn_in[0] = 1'b1;
        wait_press(0, n, rels);
        chk("pre_reset_press", n, 6);
        settle(12);
        rst = 1'b1;
        #1;
        chk("reset_async_clear", int'({btn_level, btn_press, btn_release, btn_repeat}), 0);
        settle(3);
        rst = 1'b0;
        wait_press(0, n, rels);
        chk("post_reset_press_latency", n, 6);
        chk("post_reset_no_release", rels, 0);
        btn_in[0] = 1'b0;
        settle(12);

        // Simultaneous channels
        btn_in = 2'b11;
        wait_press(0, n, rels);
        chk("simul_press_latency", n, 6);
        chk("simul_press_ch1", int'(btn_press[1]), 1);
        btn_in[1] = 1'b0;
        cnt  = 0;
        cnt2 = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (btn_release[0]) cnt++;
            if (btn_release[1]) cnt2++;
        end
        chk("simul_rel_ch0", cnt, 0);
        chk("simul_rel_ch1", cnt2, 1);
        btn_in[0] = 1'b0;
        settle(12);

        // Randomized pins with random run lengths and occasional resets
        begin
            int run[NB];
            for (int c = 0; c < NB; c++) run[c] = 0;
            for (int i = 0; i < 1500; i++) begin
                for (int c = 0; c < NB; c++) begin
                    if (run[c] == 0) begin
                        btn_in[c] = $urandom_range(0, 1);
                        run[c]    = $urandom_range(1, 30);
                    end
                    run[c]--;
                end
                if (rst) rst = ($urandom_range(0, 2) != 0);
                else     rst = ($urandom_range(0, 199) == 0);
                tick();
            end
            rst = 1'b0;
            settle(5);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
